uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Downstream consumer of the keyboard byte stream: accepts ASCII bytes via a valid/ready handshake and serialises them 8N1 on the host-bound UART TX line.
- A small FIFO absorbs back-to-back bursts, e.g. ESC + char for meta and special keys, so the keyboard state machine rarely stalls.
- Sits between the keyboard block and the top-level tx pin.

Parameters:
- CLKS_PER_BIT, 208, clk cycles per UART bit (24 MHz / 115200); legal range ≥ 2.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- data  in  8  byte to transmit.
- valid  in  1  data is valid.
- ready  out  1  FIFO can accept a byte this cycle.
- tx  out  1  UART serial output, idle high.
- busy  out  1  FIFO non-empty or a frame is in progress.

Behaviour:
- Reset and synchronicity:
  - Synchronous, active-high reset; everything changes on posedge clk.
  - Reset clears the FIFO (count=0, pointers=0), sets state IDLE, registers tx=1, and clears the baud counter and bit index.
  - Reset values of outputs: tx=1, busy=0. ready=0 while reset is asserted and 1 on the first cycle after release.
- Handshake:
  - ready = ~reset & (count != DEPTH), combinational from registered count.
  - A push occurs on any edge where valid & ready.
  - data must be held until accepted. The block never drops an accepted byte.
  - valid while ready=0 has no effect.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH.
  - count has width log2(DEPTH)+1.
  - Push and pop on the same edge leave count unchanged; both pointers advance.
  - When full, ready=0. A pop on that edge does not make ready high until the next cycle (ready is derived from the pre-edge count).
  - Pop on empty never happens. Pop is only issued when count != 0.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - Baud counter runs 0..CLKS_PER_BIT-1. A "tick" is the edge where the counter = CLKS_PER_BIT-1; the counter then reloads to 0.
  - IDLE: tx=1, counter held 0.
    - If count != 0: pop the head into the shift register, set tx<=0, go to START.
  - START: on tick, tx<=shift[0], bit index=0, go to DATA.
  - DATA: on tick, if index == 7 then tx<=1 and go to STOP; else shift right, tx<=next bit, index+1.
    - Data is sent LSB first.
  - STOP: on tick, if count != 0, pop, tx<=0, go to START (zero idle gap); else go to IDLE.
  - Every bit, including start and stop, is held exactly CLKS_PER_BIT cycles. A frame lasts 10*CLKS_PER_BIT cycles.
- Latency:
  - A byte pushed into an empty FIFO with the FSM in IDLE at edge N makes tx fall at edge N+1.
- busy = (state != IDLE) | (count != 0), combinational from registers.
- Reset mid-frame: the frame is abandoned, tx returns to 1 on the reset edge, and FIFO contents are discarded.
- No parity and no flow control input. The tx register directly drives the pin (glitch-free).

Test Plan:
- Reset, then push 8'h41 (CLKS_PER_BIT=4):
  - tx falls one cycle after the accept.
  - Sampled mid-bit every 4 cycles, tx reads 0,1,0,0,0,0,0,1,0,1.
  - busy returns to 0 exactly 40 cycles after tx fell.
- Push 8'h1B then 8'h78 on consecutive cycles:
  - Two frames back-to-back with no idle gap; the second start bit begins exactly 40 cycles after the first.
  - Decoded bytes are 1B, 78.
- With tx held busy, hold valid high with 6 distinct bytes (DEPTH=4):
  - ready drops after the FIFO fills.
  - All 6 bytes are transmitted in order, none lost or duplicated.
  - ready rises the cycle after each pop.
- Full FIFO with pop and valid in the same cycle:
  - No push that cycle (ready=0); the push occurs on the next cycle.
  - count never exceeds DEPTH.
- Assert reset during bit 3 of a frame with 2 bytes queued:
  - tx=1, busy=0, ready=0 during reset.
  - After release, nothing is transmitted until a new push.
- Sweep CLKS_PER_BIT=2 and 5 with random bytes and random valid gaps:
  - A scoreboard matches the input order exactly.
  - Every bit width is exactly CLKS_PER_BIT.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide valid/ready input, small circular FIFO, and an
// 8N1 UART serialiser that drains the FIFO onto a registered tx pin.
// Frames are sent back to back with no idle gap while the FIFO holds data.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 208,
    parameter int DEPTH        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    state_t           state_q, state_d;
    logic             tx_q, tx_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;

    logic             push;
    logic             pop;
    logic             tick;
    logic             fifo_empty;
    logic [7:0]       head;

    assign ready      = ~reset & (count_q != CNT_W'(DEPTH));
    assign push       = valid & ready;
    assign fifo_empty = (count_q == '0);
    assign tick       = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign head       = mem_q[rd_ptr_q];
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) | ~fifo_empty;

    // Serialiser next state: loads a byte from the FIFO head and steps through start, 8 data bits LSB first, and stop.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;

        if (state_q == IDLE) begin
            baud_d = '0;
        end else if (tick) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // FIFO bookkeeping: pointers wrap naturally, count tracks push minus pop.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    // All control state; reset abandons any frame and empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            tx_q      <= tx_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: three instances (4, 2 and 5 clocks per bit)
// share clock and reset; frames are checked cycle by cycle against the
// scoreboard byte so every bit width is verified, not just mid-bit values.
module tb_uart_tx_fifo;

    localparam int RX_BOUND   = 3000;
    localparam int PUSH_BOUND = 3000;

    logic       clk;
    logic       reset;
    logic [7:0] data_v [3];
    logic [2:0] valid_v;
    wire  [2:0] ready_v;
    wire  [2:0] tx_v;
    wire  [2:0] busy_v;

    int         assert_count = 0;
    int         fail_count   = 0;
    logic [7:0] sb [$];

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .data(data_v[0]), .valid(valid_v[0]),
        .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0])
    );

    uart_tx_fifo #(.CLKS_PER_BIT(2), .DEPTH(4)) u_dut2 (
        .clk(clk), .reset(reset), .data(data_v[1]), .valid(valid_v[1]),
        .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1])
    );

    uart_tx_fifo #(.CLKS_PER_BIT(5), .DEPTH(4)) u_dut5 (
        .clk(clk), .reset(reset), .data(data_v[2]), .valid(valid_v[2]),
        .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2])
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int cpb_of(input int inst);
        case (inst)
            0:       return 4;
            1:       return 2;
            default: return 5;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assert_count++;
        assert (obs === expv) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Present a byte from the next falling edge, wait for ready, and return
    // #1 after the accepting edge with valid still high.
    task automatic applyStimulus(input int inst, input logic [7:0] b, output int waits);
        waits = 0;
        @(negedge clk);
        data_v[inst]  = b;
        valid_v[inst] = 1'b1;
        while (ready_v[inst] !== 1'b1 && waits < PUSH_BOUND) begin
            waits++;
            @(negedge clk);
        end
        if (ready_v[inst] !== 1'b1) begin
            checkOutput("push_ready_timeout", {31'd0, ready_v[inst]}, 32'd1);
            valid_v[inst] = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(b);
        #1;
    endtask

    task automatic drop_valid(input int inst);
        valid_v[inst] = 1'b0;
    endtask

    // Wait for a start bit, then compare tx on every falling edge of the
    // frame against the expected 10-bit pattern and decode mid-bit samples.
    task automatic receive_frame(input int inst, input string tag, output int waited);
        int         cpb;
        int         bad;
        int         j;
        logic [7:0] exp_b;
        logic [7:0] got;
        logic [9:0] frame;
        cpb    = cpb_of(inst);
        bad    = 0;
        got    = 8'h00;
        waited = 0;
        @(negedge clk);
        while (tx_v[inst] !== 1'b0 && waited < RX_BOUND) begin
            waited++;
            @(negedge clk);
        end
        checkOutput({tag, "_start"}, {31'd0, tx_v[inst]}, 32'd0);
        if (tx_v[inst] !== 1'b0) return;
        exp_b = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        frame = {1'b1, exp_b, 1'b0};
        for (int k = 0; k < 10 * cpb; k++) begin
            if (k > 0) @(negedge clk);
            j = k / cpb;
            if (tx_v[inst] !== frame[j]) bad++;
            if ((k % cpb) == (cpb / 2) && j >= 1 && j <= 8) got[j-1] = tx_v[inst];
        end
        checkOutput({tag, "_bits"}, bad, 32'd0);
        checkOutput({tag, "_byte"}, {24'd0, got}, {24'd0, exp_b});
    endtask

    task automatic wait_idle(input int inst, input string tag);
        int n;
        n = 0;
        while (busy_v[inst] !== 1'b0 && n < RX_BOUND) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'd0, busy_v[inst]}, 32'd0);
    endtask

    // Directed sequence: reset, single frame, back-to-back, fill, reset mid-frame, sweeps.
    initial begin
        int         w;
        int         bad;
        logic [7:0] burst [6];

        reset   = 1'b1;
        valid_v = 3'b000;
        for (int i = 0; i < 3; i++) data_v[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset_tx", {31'd0, tx_v[i]}, 32'd1);
            checkOutput("reset_busy", {31'd0, busy_v[i]}, 32'd0);
            checkOutput("reset_ready", {31'd0, ready_v[i]}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("release_ready", {31'd0, ready_v[0]}, 32'd1);

        $display("[TB] single frame 0x41");
        applyStimulus(0, 8'h41, w);
        drop_valid(0);
        receive_frame(0, "t1", w);
        checkOutput("t1_latency", w, 32'd1);
        checkOutput("t1_busy_last", {31'd0, busy_v[0]}, 32'd1);
        @(negedge clk);
        checkOutput("t1_busy_end", {31'd0, busy_v[0]}, 32'd0);

        $display("[TB] back-to-back 0x1B 0x78");
        applyStimulus(0, 8'h1B, w);
        applyStimulus(0, 8'h78, w);
        drop_valid(0);
        receive_frame(0, "t2a", w);
        receive_frame(0, "t2b", w);
        checkOutput("t2_gap", w, 32'd0);
        wait_idle(0, "t2_idle");

        $display("[TB] fill FIFO with valid held");
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
        burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;
        fork
            begin
                int pw;
                for (int i = 0; i < 6; i++) begin
                    applyStimulus(0, burst[i], pw);
                    if (i == 4) checkOutput("t3_full_ready", {31'd0, ready_v[0]}, 32'd0);
                    if (i == 5) begin
                        checkOutput("t3_ready_wait", pw, 32'd37);
                        checkOutput("t3_refull_ready", {31'd0, ready_v[0]}, 32'd0);
                    end
                end
                drop_valid(0);
            end
            begin
                int rw;
                for (int i = 0; i < 6; i++) begin
                    receive_frame(0, "t3", rw);
                    if (i > 0) checkOutput("t3_gap", rw, 32'd0);
                end
            end
        join
        wait_idle(0, "t3_idle");

        $display("[TB] reset mid-frame");
        applyStimulus(0, 8'hA5, w);
        applyStimulus(0, 8'h5A, w);
        applyStimulus(0, 8'h0F, w);
        drop_valid(0);
        repeat (16) @(posedge clk);
        @(negedge clk);
        checkOutput("t5_busy_pre", {31'd0, busy_v[0]}, 32'd1);
        checkOutput("t5_bit3", {31'd0, tx_v[0]}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        checkOutput("t5_rst_tx", {31'd0, tx_v[0]}, 32'd1);
        checkOutput("t5_rst_busy", {31'd0, busy_v[0]}, 32'd0);
        checkOutput("t5_rst_ready", {31'd0, ready_v[0]}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("t5_rel_ready", {31'd0, ready_v[0]}, 32'd1);
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
        end
        checkOutput("t5_quiet", bad, 32'd0);
        applyStimulus(0, 8'hC3, w);
        drop_valid(0);
        receive_frame(0, "t5_new", w);
        wait_idle(0, "t5_idle");

        for (int inst = 1; inst < 3; inst++) begin
            $display("[TB] random sweep, %0d clocks per bit", cpb_of(inst));
            sb.delete();
            fork
                begin
                    int pw;
                    int gap;
                    for (int i = 0; i < 12; i++) begin
                        gap = int'($urandom_range(0, 12));
                        if (gap > 0) begin
                            drop_valid(inst);
                            repeat (gap) @(posedge clk);
                            #1;
                        end
                        applyStimulus(inst, 8'($urandom_range(0, 255)), pw);
                    end
                    drop_valid(inst);
                end
                begin
                    int rw;
                    for (int i = 0; i < 12; i++) receive_frame(inst, "sweep", rw);
                end
            join
            wait_idle(inst, "sweep_idle");
            checkOutput("sweep_drained", sb.size(), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
